// File: rtl/change_dispenser.sv
// change_dispenser: releases the purchased item, then pays out returned change
// as 50/20/10 coins over a req/ack handshake with the coin hopper. A one-deep
// pending slot holds a request that arrives while a dispense is in progress.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       purchase,
    input  logic [2:0] ret,
    input  logic       hopper_ack,
    output logic       item_drop,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [3:0] change_left,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       fault,
    output logic       code_err
);

    localparam int unsigned UW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITEM,
        S_COIN,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state_q;
    logic [UW-1:0]   units_q;
    logic            pend_valid_q;
    logic            pend_pur_q;
    logic [UW-1:0]   pend_units_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            overflow_q;
    logic            code_err_q;

    logic            req_c;
    logic [UW-1:0]   req_units_c;
    logic [UW-1:0]   coin_val_c;
    logic [1:0]      coin_code_c;

    // Change code to units of 10; the illegal code pays nothing.
    function automatic logic [UW-1:0] decode_units(input logic [2:0] code);
        case (code)
            3'b001:  decode_units = UW'(2);
            3'b010:  decode_units = UW'(3);
            3'b011:  decode_units = UW'(4);
            3'b100:  decode_units = UW'(5);
            3'b101:  decode_units = UW'(7);
            3'b110:  decode_units = UW'(9);
            default: decode_units = UW'(0);
        endcase
    endfunction

    // First state of a freshly loaded transaction.
    function automatic state_t load_state(input logic pur, input logic [UW-1:0] u);
        if (pur)               load_state = S_ITEM;
        else if (u != UW'(0))  load_state = S_COIN;
        else                   load_state = S_DONE;
    endfunction

    // Request detection and greedy coin choice for the active amount.
    always_comb begin
        req_c       = purchase | (ret != 3'b000);
        req_units_c = decode_units(ret);
        coin_val_c  = UW'(1);
        coin_code_c = 2'b01;
        if (units_q >= UW'(5)) begin
            coin_val_c  = UW'(5);
            coin_code_c = 2'b11;
        end else if (units_q >= UW'(2)) begin
            coin_val_c  = UW'(2);
            coin_code_c = 2'b10;
        end
    end

    // Transaction FSM, pending slot, timeout counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            units_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_pur_q   <= 1'b0;
            pend_units_q <= '0;
            to_cnt_q     <= '0;
            overflow_q   <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            if (ret == 3'b111) code_err_q <= 1'b1;

            // Outside IDLE a request can only be parked or dropped.
            if (state_q != S_IDLE && req_c) begin
                if (!pend_valid_q) begin
                    pend_valid_q <= 1'b1;
                    pend_pur_q   <= purchase;
                    pend_units_q <= req_units_c;
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (pend_valid_q) begin
                        state_q      <= load_state(pend_pur_q, pend_units_q);
                        units_q      <= pend_units_q;
                        pend_valid_q <= req_c;
                        pend_pur_q   <= purchase;
                        pend_units_q <= req_units_c;
                    end else if (req_c) begin
                        state_q <= load_state(purchase, req_units_c);
                        units_q <= req_units_c;
                    end
                end
                S_ITEM: state_q <= (units_q != UW'(0)) ? S_COIN : S_DONE;
                S_COIN: begin
                    if (hopper_ack) begin
                        units_q  <= units_q - coin_val_c;
                        to_cnt_q <= '0;
                        state_q  <= (units_q == coin_val_c) ? S_DONE : S_GAP;
                    end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                        state_q <= S_FAULT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_GAP:   state_q <= S_COIN;
                S_DONE:  state_q <= S_IDLE;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    assign item_drop   = (state_q == S_ITEM);
    assign coin_req    = (state_q == S_COIN);
    assign coin_sel    = (state_q == S_COIN) ? coin_code_c : 2'b00;
    assign change_left = (state_q == S_IDLE) ? 4'd0 : units_q;
    assign busy        = (state_q != S_IDLE) | pend_valid_q;
    assign done        = (state_q == S_DONE);
    assign fault       = (state_q == S_FAULT);
    assign overflow    = overflow_q;
    assign code_err    = code_err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a vector table for single transactions
// plus hand-written sequences for pending/overflow, timeout and reset.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       purchase;
    logic [2:0] ret;
    logic       hopper_ack;
    logic       item_drop;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic [3:0] change_left;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       fault;
    logic       code_err;

    int errors = 0;
    int checks = 0;

    change_dispenser #(.ACK_TIMEOUT(15), .TO_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .purchase    (purchase),
        .ret         (ret),
        .hopper_ack  (hopper_ack),
        .item_drop   (item_drop),
        .coin_req    (coin_req),
        .coin_sel    (coin_sel),
        .change_left (change_left),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .fault       (fault),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pur;
        logic [2:0] rt;
        logic       ack;
        logic       id;
        logic       cr;
        logic [1:0] sel;
        logic [3:0] left;
        logic       bsy;
        logic       dn;
        logic       ov;
        logic       flt;
        logic       ce;
    } vec_t;

    vec_t vecs[$];

    // Output order: item_drop coin_req coin_sel change_left busy done overflow fault code_err
    function automatic logic [12:0] outs();
        return {item_drop, coin_req, coin_sel, change_left, busy, done, overflow, fault, code_err};
    endfunction

    task automatic add(input logic r, input logic p, input logic [2:0] rt, input logic a,
                       input logic id, input logic cr, input logic [1:0] sel, input logic [3:0] left,
                       input logic bsy, input logic dn, input logic ov, input logic flt, input logic ce);
        vec_t v;
        v.rst = r; v.pur = p; v.rt = rt; v.ack = a;
        v.id = id; v.cr = cr; v.sel = sel; v.left = left;
        v.bsy = bsy; v.dn = dn; v.ov = ov; v.flt = flt; v.ce = ce;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic p, input logic [2:0] rt, input logic a);
        reset = r; purchase = p; ret = rt; hopper_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1; purchase = 1'b0; ret = 3'b000; hopper_ack = 1'b0;

        //   rst p  ret  ack | id cr sel left bsy dn ov flt ce
        add(1, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);
        // 90 with purchase, ack one cycle after each coin_req rise
        add(0, 1, 3'd6, 0,   1, 0, 2'd0, 4'd9, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd3, 4'd9, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd3, 4'd9, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 1,   0, 0, 2'd0, 4'd4, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd2, 4'd4, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd2, 4'd4, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 1,   0, 0, 2'd0, 4'd2, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd2, 4'd2, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 1, 2'd2, 4'd2, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 1,   0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);
        // purchase only: item, then done
        add(0, 1, 3'd0, 0,   1, 0, 2'd0, 4'd0, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);
        // stray ack in IDLE is ignored
        add(0, 0, 3'd0, 1,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);
        // 50 without purchase, immediate ack: single coin then done
        add(0, 0, 3'd4, 0,   0, 1, 2'd3, 4'd5, 1, 0, 0, 0, 0);
        add(0, 0, 3'd0, 1,   0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 0);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);
        // illegal code with purchase: item, no coins, sticky code_err
        add(0, 1, 3'd7, 0,   1, 0, 2'd0, 4'd0, 1, 0, 0, 0, 1);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 1);
        add(0, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 1);
        add(1, 0, 3'd0, 0,   0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            step(v.rst, v.pur, v.rt, v.ack);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({v.id, v.cr, v.sel, v.left, v.bsy, v.dn, v.ov, v.flt, v.ce}));
        end

        // 40 then 30 arriving while busy: pending slot, no overflow
        step(0, 0, 3'd3, 0); chk("A_coin1", 32'({coin_req, coin_sel, change_left}), 32'({1'b1, 2'd2, 4'd4}));
        step(0, 0, 3'd0, 0);
        step(0, 0, 3'd2, 1); chk("A_gap1", 32'({coin_req, change_left, busy}), 32'({1'b0, 4'd2, 1'b1}));
        step(0, 0, 3'd0, 0); chk("A_coin2", 32'({coin_req, coin_sel}), 32'({1'b1, 2'd2}));
        step(0, 0, 3'd0, 1); chk("A_done1", 32'({done, change_left}), 32'({1'b1, 4'd0}));
        step(0, 0, 3'd0, 0); chk("A_idle_pend", 32'({coin_req, busy, done}), 32'({1'b0, 1'b1, 1'b0}));
        step(0, 0, 3'd0, 0); chk("A_coin3", 32'({coin_req, coin_sel, change_left}), 32'({1'b1, 2'd2, 4'd3}));
        step(0, 0, 3'd0, 1); chk("A_gap3", 32'(change_left), 32'd1);
        step(0, 0, 3'd0, 0); chk("A_coin4", 32'({coin_req, coin_sel}), 32'({1'b1, 2'd1}));
        step(0, 0, 3'd0, 1); chk("A_done2", 32'(done), 32'd1);
        step(0, 0, 3'd0, 0); chk("A_end", 32'({busy, overflow}), 32'd0);

        // three back-to-back requests: third dropped, overflow sticky
        step(0, 0, 3'd3, 0);
        step(0, 0, 3'd2, 0); chk("B_no_ovf", 32'(overflow), 32'd0);
        step(0, 0, 3'd1, 0); chk("B_ovf", 32'(overflow), 32'd1);
        step(0, 0, 3'd0, 1);
        step(0, 0, 3'd0, 0);
        step(0, 0, 3'd0, 1); chk("B_done1", 32'(done), 32'd1);
        step(0, 0, 3'd0, 0); chk("B_idle_pend", 32'(busy), 32'd1);
        step(0, 0, 3'd0, 0); chk("B_second", 32'({coin_sel, change_left}), 32'({2'd2, 4'd3}));
        step(0, 0, 3'd0, 1);
        step(0, 0, 3'd0, 0); chk("B_coin10", 32'({coin_req, coin_sel}), 32'({1'b1, 2'd1}));
        step(0, 0, 3'd0, 1); chk("B_done2", 32'(done), 32'd1);
        step(0, 0, 3'd0, 0); chk("B_end", 32'({busy, overflow}), 32'({1'b0, 1'b1}));
        step(1, 0, 3'd0, 0); chk("B_reset", 32'(outs()), 32'd0);

        // hopper never acks: 15 cycles of coin_req then fault
        step(0, 0, 3'd4, 0);
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            if (!(coin_req && coin_sel == 2'd3 && !fault)) bad++;
            step(0, 0, 3'd0, 0);
        end
        chk("C_wait", 32'(bad), 32'd0);
        chk("C_last_req", 32'({coin_req, coin_sel, fault}), 32'({1'b1, 2'd3, 1'b0}));
        step(0, 0, 3'd0, 0);
        chk("C_fault", 32'({coin_req, coin_sel, fault, busy, change_left}), 32'({1'b0, 2'd0, 1'b1, 1'b1, 4'd5}));
        step(0, 0, 3'd2, 0); chk("C_pend", 32'({fault, overflow}), 32'({1'b1, 1'b0}));
        step(0, 0, 3'd2, 1); chk("C_ovf", 32'({fault, overflow, coin_req}), 32'({1'b1, 1'b1, 1'b0}));
        step(1, 0, 3'd0, 0); chk("C_reset", 32'(outs()), 32'd0);

        // reset mid-COIN abandons the transaction without done
        step(0, 0, 3'd6, 0); chk("D_coin", 32'(coin_req), 32'd1);
        step(0, 0, 3'd0, 0);
        step(1, 0, 3'd0, 1); chk("D_reset", 32'(outs()), 32'd0);
        step(0, 0, 3'd0, 0); chk("D_after", 32'(outs()), 32'd0);
        step(0, 0, 3'd0, 0); chk("D_after2", 32'(outs()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
